// File: rtl/pen_servo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pen_servo_pkg
// Purpose  : Shared types and default constants for the pen-lift servo stage
//            that feeds the Pwm block.
// Contents : pen_servo_state_t       - controller state encoding
//            PEN_UP_DUTY             - default duty for the raised pen
//            PEN_DOWN_DUTY           - default duty for the lowered pen
//            DEFAULT_PWM_PERIOD      - default Pwm period
//            DEFAULT_PERIOD_BITS     - default width of period/duty
// Revision : 1.0 - initial release
// ============================================================================
package pen_servo_pkg;

    localparam int DEFAULT_PERIOD_BITS = 8;
    localparam int DEFAULT_PWM_PERIOD  = 200;
    localparam int PEN_UP_DUTY         = 10;
    localparam int PEN_DOWN_DUTY       = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2
    } pen_servo_state_t;

endpackage : pen_servo_pkg
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : settle_timer
// Purpose  : Loadable down-counter that decrements once per clk_en tick and
//            flags when it has reached zero. Shared by the motion stages.
// Ports    : clk        - system clock
//            reset      - asynchronous active-low reset (count clears to 0)
//            clk_en     - decrement tick
//            load       - load load_value (takes priority over decrement)
//            load_value - value to load
//            expired    - count is zero
// Revision : 1.0 - initial release
// ============================================================================
module settle_timer
    import pen_servo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Saturates at zero so an idle timer stays expired.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (clk_en && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    assign expired = (r_count == '0);

endmodule : settle_timer
`default_nettype wire

// File: rtl/pen_servo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pen_servo_ctrl
// Purpose  : Pen-lift servo controller upstream of Pwm. Accepts pen up/down
//            commands over valid/ready, moves duty_cycle to the target, holds
//            for a settle time counted in clk_en ticks, then pulses done.
// Build    : PEN_SERVO_RAMP_EN defined   -> duty steps by one per clk_en tick
//            PEN_SERVO_RAMP_EN undefined -> duty jumps to target on accept
// Ports    : clk          - system clock
//            reset        - asynchronous active-low reset
//            clk_en       - tick shared with Pwm (ramp/settle time base)
//            cmd_valid    - command present
//            cmd_pen_down - 1 = lower pen, 0 = raise pen
//            cmd_ready    - controller idle, command can be accepted
//            period       - constant PWM_PERIOD to Pwm
//            duty_cycle   - duty to Pwm
//            done         - one-cycle pulse on the cycle the move completes
//            pen_is_down  - last completed pen position
// Revision : 1.0 - initial release
// ============================================================================
module pen_servo_ctrl
    import pen_servo_pkg::*;
#(
    parameter int PERIOD_BITS  = DEFAULT_PERIOD_BITS,
    parameter int PWM_PERIOD   = DEFAULT_PWM_PERIOD,
    parameter int UP_DUTY      = PEN_UP_DUTY,
    parameter int DOWN_DUTY    = PEN_DOWN_DUTY,
    parameter int SETTLE_TICKS = 50,
    parameter int SETTLE_BITS  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic                   cmd_valid,
    input  logic                   cmd_pen_down,
    output logic                   cmd_ready,
    output logic [PERIOD_BITS-1:0] period,
    output logic [PERIOD_BITS-1:0] duty_cycle,
    output logic                   done,
    output logic                   pen_is_down
);

    localparam logic [PERIOD_BITS-1:0] c_period    = PERIOD_BITS'(PWM_PERIOD);
    localparam logic [PERIOD_BITS-1:0] c_up_duty   = PERIOD_BITS'(UP_DUTY);
    localparam logic [PERIOD_BITS-1:0] c_down_duty = PERIOD_BITS'(DOWN_DUTY);
    localparam logic [SETTLE_BITS-1:0] c_settle    = SETTLE_BITS'(SETTLE_TICKS);
    localparam logic                   c_no_settle = (SETTLE_TICKS == 0);

    generate
        if ((UP_DUTY > PWM_PERIOD) || (DOWN_DUTY > PWM_PERIOD) ||
            (UP_DUTY < 0) || (DOWN_DUTY < 0) ||
            ((PERIOD_BITS < 31) && (PWM_PERIOD >= (1 << PERIOD_BITS))) ||
            ((SETTLE_BITS < 31) && (SETTLE_TICKS >= (1 << SETTLE_BITS)))) begin : g_param_check
            $error("pen_servo_ctrl: duty/period/settle parameters out of range");
        end
    endgenerate

    pen_servo_state_t       r_state, w_next_state;
    logic [PERIOD_BITS-1:0] r_duty, w_next_duty;
    logic                   r_req_down, w_next_req_down;
    logic                   r_pen_down, w_next_pen_down;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_expired;
    logic                   w_settle_fire;
    logic                   w_done;
    logic [PERIOD_BITS-1:0] w_cmd_target;

`ifdef PEN_SERVO_RAMP_EN
    localparam logic [PERIOD_BITS-1:0] c_one = PERIOD_BITS'(1);
    logic [PERIOD_BITS-1:0] r_target, w_next_target;
`endif

    assign w_accept      = cmd_valid && (r_state == IDLE);
    assign w_cmd_target  = cmd_pen_down ? c_down_duty : c_up_duty;
    // A zero settle time completes without waiting for a tick.
    assign w_settle_fire = w_expired && (clk_en || c_no_settle);

    always_comb begin
        w_next_state    = r_state;
        w_next_duty     = r_duty;
        w_next_req_down = r_req_down;
        w_next_pen_down = r_pen_down;
        w_load          = 1'b0;
        w_done          = 1'b0;
`ifdef PEN_SERVO_RAMP_EN
        w_next_target   = r_target;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_req_down = cmd_pen_down;
`ifdef PEN_SERVO_RAMP_EN
                    w_next_target   = w_cmd_target;
                    w_next_state    = RAMP;
`else
                    w_next_duty     = w_cmd_target;
                    w_load          = 1'b1;
                    w_next_state    = SETTLE;
`endif
                end
            end
            RAMP: begin
`ifdef PEN_SERVO_RAMP_EN
                // Arrival is judged on the registered duty, so a step taken
                // on a tick is followed by one cycle that starts the settle.
                if (r_duty == r_target) begin
                    w_load       = 1'b1;
                    w_next_state = SETTLE;
                end else if (clk_en) begin
                    w_next_duty = (r_duty < r_target) ? (r_duty + c_one)
                                                      : (r_duty - c_one);
                end
`else
                w_next_state = IDLE;
`endif
            end
            SETTLE: begin
                if (w_settle_fire) begin
                    w_done          = 1'b1;
                    w_next_pen_down = r_req_down;
                    w_next_state    = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_duty     <= c_up_duty;
            r_req_down <= 1'b0;
            r_pen_down <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_duty     <= w_next_duty;
            r_req_down <= w_next_req_down;
            r_pen_down <= w_next_pen_down;
        end
    end

`ifdef PEN_SERVO_RAMP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_target <= c_up_duty;
        end else begin
            r_target <= w_next_target;
        end
    end
`endif

    settle_timer #(
        .WIDTH      (SETTLE_BITS)
    ) u_settle_timer (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .load       (w_load),
        .load_value (c_settle),
        .expired    (w_expired)
    );

    assign period      = c_period;
    assign duty_cycle  = r_duty;
    assign cmd_ready   = (r_state == IDLE);
    assign done        = w_done;
    assign pen_is_down = r_pen_down;

endmodule : pen_servo_ctrl
`default_nettype wire

// File: tb/tb_pen_servo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pen_servo_ctrl
// Purpose  : Directed self-checking bench for pen_servo_ctrl with
//            PWM_PERIOD=5, UP_DUTY=2, DOWN_DUTY=4, SETTLE_TICKS=3 and clk_en
//            high every second clock. Follows PEN_SERVO_RAMP_EN like the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pen_servo_ctrl;

    localparam int PB     = 8;
    localparam int C_UP   = 2;
    localparam int C_DOWN = 4;
    localparam int C_SET  = 3;
    localparam int C_PER  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en;
    logic          cmd_valid;
    logic          cmd_pen_down;
    logic          cmd_ready;
    logic [PB-1:0] period;
    logic [PB-1:0] duty_cycle;
    logic          done;
    logic          pen_is_down;

    int n_checks = 0;
    int n_errors = 0;
    bit r_phase  = 1'b0;

    pen_servo_ctrl #(
        .PERIOD_BITS  (PB),
        .PWM_PERIOD   (C_PER),
        .UP_DUTY      (C_UP),
        .DOWN_DUTY    (C_DOWN),
        .SETTLE_TICKS (C_SET),
        .SETTLE_BITS  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .cmd_valid    (cmd_valid),
        .cmd_pen_down (cmd_pen_down),
        .cmd_ready    (cmd_ready),
        .period       (period),
        .duty_cycle   (duty_cycle),
        .done         (done),
        .pen_is_down  (pen_is_down)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; clk_en alternates and everything is sampled 2 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        r_phase = ~r_phase;
        clk_en  = r_phase;
        #1;
    endtask

    // Advance until an edge with clk_en high has been taken.
    task automatic wait_en_edge();
        bit was;
        do begin
            was = clk_en;
            cyc();
        end while (!was);
    endtask

    // Present a command and take the accept edge.
    task automatic issue(input string tag, input logic down, input bit hold);
        cmd_valid    = 1'b1;
        cmd_pen_down = down;
        check({tag, "_ready_pre"}, 32'(cmd_ready), 1);
        cyc();
        if (!hold) cmd_valid = 1'b0;
        check({tag, "_ready_post"}, 32'(cmd_ready), 0);
    endtask

    // Called on the first SETTLE cycle: done must land on the tick after
    // C_SET ticks, last exactly one cycle, and leave the block idle.
    task automatic wait_done(input string tag, input logic exp_pen, input int exp_duty);
        int ticks = 0;
        bit seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
                check({tag, "_ticks"},   ticks, C_SET);
                check({tag, "_done_en"}, 32'(clk_en), 1);
                check({tag, "_busy"},    32'(cmd_ready), 0);
                check({tag, "_duty"},    32'(duty_cycle), exp_duty);
            end else begin
                if (clk_en) ticks++;
                cyc();
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        cyc();
        check({tag, "_done_pulse"}, 32'(done), 0);
        check({tag, "_ready_idle"}, 32'(cmd_ready), 1);
        check({tag, "_pen"},        32'(pen_is_down), 32'(exp_pen));
    endtask

    initial begin
        reset        = 1'b0;
        clk_en       = 1'b0;
        cmd_valid    = 1'b0;
        cmd_pen_down = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;

        // Reset values
        check("rst_period", 32'(period), C_PER);
        check("rst_duty",   32'(duty_cycle), C_UP);
        check("rst_ready",  32'(cmd_ready), 1);
        check("rst_done",   32'(done), 0);
        check("rst_pen",    32'(pen_is_down), 0);
        cyc();

        // Pen-up while already up: duty stays, settle still applies
        issue("upup", 1'b0, 1'b0);
        check("upup_duty", 32'(duty_cycle), C_UP);
`ifdef PEN_SERVO_RAMP_EN
        cyc();
        check("upup_duty_ramp", 32'(duty_cycle), C_UP);
`endif
        wait_done("upup", 1'b0, C_UP);

        // Pen-down
        check("down_duty_pre", 32'(duty_cycle), C_UP);
        issue("down", 1'b1, 1'b0);
`ifdef PEN_SERVO_RAMP_EN
        check("down_duty_0", 32'(duty_cycle), 2);
        wait_en_edge();
        check("down_duty_1", 32'(duty_cycle), 3);
        wait_en_edge();
        check("down_duty_2", 32'(duty_cycle), 4);
        cyc();
`else
        check("down_duty_jump", 32'(duty_cycle), C_DOWN);
`endif
        check("down_period", 32'(period), C_PER);
        wait_done("down", 1'b1, C_DOWN);

        // Pen-down while down, with a pen-up held on valid during the move
        issue("busy", 1'b1, 1'b1);
        cmd_pen_down = 1'b0;
`ifdef PEN_SERVO_RAMP_EN
        cyc();
`endif
        check("busy_duty", 32'(duty_cycle), C_DOWN);
        wait_done("busy", 1'b1, C_DOWN);
        // Held command is accepted on the first idle edge
        cyc();
        cmd_valid = 1'b0;
        check("held_accepted", 32'(cmd_ready), 0);
`ifdef PEN_SERVO_RAMP_EN
        check("held_duty_0", 32'(duty_cycle), 4);
        wait_en_edge();
        check("held_duty_1", 32'(duty_cycle), 3);
        wait_en_edge();
        check("held_duty_2", 32'(duty_cycle), 2);
        cyc();
`else
        check("held_duty_jump", 32'(duty_cycle), C_UP);
`endif
        wait_done("held", 1'b0, C_UP);

        // Reset in the middle of a move takes effect without a clock edge
        issue("mid", 1'b1, 1'b0);
`ifdef PEN_SERVO_RAMP_EN
        wait_en_edge();
        check("mid_duty", 32'(duty_cycle), 3);
`else
        check("mid_duty", 32'(duty_cycle), C_DOWN);
`endif
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_duty",  32'(duty_cycle), C_UP);
        check("mid_rst_done",  32'(done), 0);
        check("mid_rst_ready", 32'(cmd_ready), 1);
        check("mid_rst_pen",   32'(pen_is_down), 0);
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        check("post_rst_ready", 32'(cmd_ready), 1);
        check("post_rst_duty",  32'(duty_cycle), C_UP);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pen_servo_ctrl
`default_nettype wire

// File: doc/pen_servo_ctrl.md
Name: pen_servo_ctrl

Overview:
- Upstream stage of the Pwm block; drives the pen-lift servo of the plotter.
- Accepts pen up/down commands over a valid/ready handshake.
- Ramps the `duty_cycle` it presents to Pwm one step per `clk_en` tick, waits a settle time, then pulses `done`.
- Shares the same `ClockEnabler` tick as Pwm, so the ramp rate is tied to the PWM time base.

Parameters:
- PERIOD_BITS, 8 (BYTE_BITS), width of `period` and `duty_cycle`.
- PWM_PERIOD, 200, constant value driven on `period`.
- UP_DUTY, 10, duty for pen raised; also the reset duty.
- DOWN_DUTY, 20, duty for pen lowered.
- SETTLE_TICKS, 50, `clk_en` ticks held after reaching target.
- SETTLE_BITS, 16, width of the settle counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clk_en  in  1  one-cycle tick from ClockEnabler.
- cmd_valid  in  1  command present.
- cmd_pen_down  in  1  1 = lower pen, 0 = raise pen.
- cmd_ready  out  1  block can accept a command.
- period  out  PERIOD_BITS  to Pwm `period`.
- duty_cycle  out  PERIOD_BITS  to Pwm `duty_cycle`.
- done  out  1  one-cycle pulse when the move has settled.
- pen_is_down  out  1  last completed pen position.

Behaviour:
- Reset (reset=0, async): state=IDLE, duty_cycle=UP_DUTY, period=PWM_PERIOD, cmd_ready=1, done=0, pen_is_down=0, settle counter=0.
- `period` is constant PWM_PERIOD at all times.
- Accept occurs on a rising clk edge with cmd_valid && cmd_ready.
- IDLE:
  - cmd_ready=1.
  - On accept: latch target = cmd_pen_down ? DOWN_DUTY : UP_DUTY; latch the requested pen position; go to RAMP on the next cycle; cmd_ready drops the cycle after accept.
- RAMP:
  - cmd_ready=0.
  - Each cycle with clk_en=1: if duty_cycle<target, duty_cycle+1; if >target, duty_cycle−1.
  - On the cycle duty_cycle==target (evaluated on registered value): load settle counter = SETTLE_TICKS, go to SETTLE.
  - If target already equals duty_cycle at accept, RAMP lasts exactly one cycle and goes straight to SETTLE. The settle time still applies.
- SETTLE:
  - cmd_ready=0.
  - Counter decrements on clk_en.
  - When the counter is 0 and clk_en=1 (or SETTLE_TICKS=0 on entry): pulse done for one cycle, update pen_is_down to the latched request, return to IDLE.
- Arithmetic: unsigned, width PERIOD_BITS; steps never overshoot target; no wrap possible.
- Commands while busy: cmd_ready=0, so no accept; cmd_valid may stay high and is accepted in the first IDLE cycle.
- done and accept never occur in the same cycle; done is asserted in the cycle the state returns to IDLE.
- Reset mid-operation: immediate return to reset values. Any in-flight command is lost and the duty snaps to UP_DUTY (safe pen-up).
- clk_en held low: state and duty freeze; the handshake is still accepted in IDLE.
- Parameter legality: UP_DUTY and DOWN_DUTY ≤ PWM_PERIOD; checked with an elaboration-time assertion.

Optional Feature:
- Macro: PEN_SERVO_RAMP_EN.
- Defined: ramp behaviour as above.
- Undefined: no RAMP state is used. On accept, duty_cycle is loaded with target on the next clk edge and the state goes directly to SETTLE. The settle and done rules are unchanged, and the step-toward-target logic is not synthesised.

Decomposition:
- Shared package `pen_servo_pkg`:
  - state enum `pen_servo_state_t` {IDLE, RAMP, SETTLE};
  - default duty constants PEN_UP_DUTY and PEN_DOWN_DUTY;
  - default PWM_PERIOD.
- Sub-module `settle_timer`: loadable down-counter with clk_en decrement and an `expired` flag. It is reusable by the motor stages.

Test Plan (PWM_PERIOD=5, UP_DUTY=2, DOWN_DUTY=4, SETTLE_TICKS=3, clk_en every 2 clks):
- Reset release → period=5, duty_cycle=2, cmd_ready=1, done=0, pen_is_down=0.
- Pen-down cmd → duty 2→3→4 on successive clk_en; done pulses once after 3 further ticks; pen_is_down=1; cmd_ready returns 1.
- Pen-up cmd issued while pen is up → no duty change, done after 3 ticks, pen_is_down stays 0.
- cmd_valid held high during a move with a second pen-up command → not accepted until IDLE; then duty ramps 4→3→2.
- Reset asserted mid-RAMP (duty=3) → duty_cycle=2, state IDLE, done=0 immediately, without waiting for a clk edge.
- PEN_SERVO_RAMP_EN undefined, pen-down cmd → duty jumps 2→4 one clk after accept; done after 3 ticks.
